// File: rtl/alu_pipe.sv
// alu_pipe: parametrised registered ALU with valid/ready handshakes.
// Single-cycle ops retire one cycle after accept; MUL runs a WIDTH-step
// shift-add loop. Results and flags are held in OUT until the consumer
// accepts them.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    state_t             state;
    logic [2*WIDTH-1:0] mcand, acc, acc_n;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               accept;

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] shl_w, shr_w;
    logic [WIDTH-1:0]   r_y;
    logic               r_c, r_v;

    // Ready depends only on state and out_ready, never on in_valid.
    assign in_ready = (state == IDLE) | ((state == OUT) & out_ready);
    assign accept   = in_valid & in_ready;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign acc_n = acc + (mplier[0] ? mcand : {2*WIDTH{1'b0}});

    // Single-cycle datapath. Shifts are done in a double-width field so the
    // last bit shifted out lands in a fixed position (bit WIDTH for SHL,
    // bit WIDTH-1 for SHR) and out-of-range amounts naturally give zero.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        shl_w = {{WIDTH{1'b0}}, a} << b;
        shr_w = {a, {WIDTH{1'b0}}} >> b;
        r_y   = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        case (op)
            OP_ADD: begin
                r_y = sum[WIDTH-1:0];
                r_c = sum[WIDTH];
                r_v = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r_y = diff[WIDTH-1:0];
                r_c = diff[WIDTH];
                r_v = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r_y = a & b;
            OP_OR:  r_y = a | b;
            OP_XOR: r_y = a ^ b;
            OP_SHL: begin
                r_y = shl_w[WIDTH-1:0];
                r_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                r_y = shr_w[2*WIDTH-1:WIDTH];
                r_c = shr_w[WIDTH-1];
            end
            default: ;
        endcase
    end

    // Control FSM with registered result, flags and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            y         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                MUL: begin
                    acc    <= acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        // Final step: publish the product straight from acc_n.
                        state     <= OUT;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        y         <= acc_n[WIDTH-1:0];
                        carry     <= |acc_n[2*WIDTH-1:WIDTH];
                        zero      <= (acc_n[WIDTH-1:0] == '0);
                        neg       <= acc_n[WIDTH-1];
                        ovf       <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE, OUT: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state     <= MUL;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            acc       <= '0;
                            mcand     <= {{WIDTH{1'b0}}, a};
                            mplier    <= b;
                            cnt       <= '0;
                        end else begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            y         <= r_y;
                            carry     <= r_c;
                            zero      <= (r_y == '0);
                            neg       <= r_y[WIDTH-1];
                            ovf       <= r_v;
                        end
                    end else if ((state == OUT) && out_ready) begin
                        // Retire without a follow-on request; keep y/flags.
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b, y;
    logic         carry, zero, neg, ovf, busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; a = '0; b = '0;
        #12;
        n_cmp++;
        if ({out_valid, y, carry, zero, neg, ovf, busy, in_ready} !== {1'b0, 8'd0, 5'b00000, 1'b1}) begin
            n_err++;
            $display("FAIL reset: got ov=%b y=%0d c=%b z=%b n=%b v=%b busy=%b rdy=%b, want 0,0,0,0,0,0,0,1",
                     out_valid, y, carry, zero, neg, ovf, busy, in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        in_valid = 1'b1; op = 3'd0; a = 8'd200; b = 8'd100;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, y, carry, ovf, zero, neg} !== {1'b1, 8'd44, 4'b1000}) begin
            n_err++;
            $display("FAIL add_200_100: got ov=%b y=%0d c=%b v=%b z=%b n=%b, want 1,44,1,0,0,0",
                     out_valid, y, carry, ovf, zero, neg);
        end
        // Signed overflow: 100+100 = 200 (-56 signed)
        in_valid = 1'b1; a = 8'd100; b = 8'd100;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, y, carry, ovf, neg} !== {1'b1, 8'd200, 3'b011}) begin
            n_err++;
            $display("FAIL add_ovf: got ov=%b y=%0d c=%b v=%b n=%b, want 1,200,0,1,1",
                     out_valid, y, carry, ovf, neg);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL add_retire: got ov=%b rdy=%b, want 0,1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; op = 3'd1; a = 8'd8; b = 8'd6;
        step();
        n_cmp++;
        if ({out_valid, y, carry, in_ready} !== {1'b1, 8'd2, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sub_8_6: got ov=%b y=%0d c=%b rdy=%b, want 1,2,0,1", out_valid, y, carry, in_ready);
        end
        a = 8'd6; b = 8'd8;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, y, carry, neg, ovf} !== {1'b1, 8'd254, 3'b110}) begin
            n_err++;
            $display("FAIL sub_6_8: got ov=%b y=%0d c=%b n=%b v=%b, want 1,254,1,1,0",
                     out_valid, y, carry, neg, ovf);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_retire: got ov=%b, want 0", out_valid);
        end
    endtask

    task automatic test_mul();
        in_valid = 1'b1; op = 3'd7; a = 8'd15; b = 8'd17;
        step();
        in_valid = 1'b0; a = 8'hAA; b = 8'h55;  // must not disturb the product
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if ({busy, in_ready, out_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL mul_busy cyc%0d: got busy=%b rdy=%b ov=%b, want 1,0,0", i + 1, busy, in_ready, out_valid);
            end
            step();
        end
        n_cmp++;
        if ({out_valid, busy, y, carry, zero} !== {2'b10, 8'd255, 2'b00}) begin
            n_err++;
            $display("FAIL mul_15_17: got ov=%b busy=%b y=%0d c=%b z=%b, want 1,0,255,0,0",
                     out_valid, busy, y, carry, zero);
        end
        // Back-to-back MUL from OUT
        in_valid = 1'b1; op = 3'd7; a = 8'd16; b = 8'd16;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL mul_start: got ov=%b busy=%b, want 0,1", out_valid, busy);
        end
        repeat (W) step();
        n_cmp++;
        if ({out_valid, y, carry, zero} !== {1'b1, 8'd0, 2'b11}) begin
            n_err++;
            $display("FAIL mul_16_16: got ov=%b y=%0d c=%b z=%b, want 1,0,1,1", out_valid, y, carry, zero);
        end
        step();
    endtask

    task automatic test_shift_logic();
        in_valid = 1'b1; op = 3'd5; a = 8'h81; b = 8'd1;
        step();
        n_cmp++;
        if ({y, carry} !== {8'h02, 1'b1}) begin
            n_err++;
            $display("FAIL shl_1: got y=%h c=%b, want 02,1", y, carry);
        end
        op = 3'd6; b = 8'd9;
        step();
        n_cmp++;
        if ({y, carry, zero} !== {8'h00, 2'b01}) begin
            n_err++;
            $display("FAIL shr_9: got y=%h c=%b z=%b, want 00,0,1", y, carry, zero);
        end
        op = 3'd6; b = 8'd8;
        step();
        n_cmp++;
        if ({y, carry} !== {8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL shr_8: got y=%h c=%b, want 00,1", y, carry);
        end
        op = 3'd5; a = 8'h80; b = 8'd3;
        step();
        n_cmp++;
        if ({y, carry} !== {8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL shl_3: got y=%h c=%b, want 00,0", y, carry);
        end
        op = 3'd4; a = 8'hF0; b = 8'hFF;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({y, carry, zero} !== {8'h0F, 2'b00}) begin
            n_err++;
            $display("FAIL xor: got y=%h c=%b z=%b, want 0f,0,0", y, carry, zero);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; a = 8'd8; b = 8'd6;
        step();
        a = 8'd1; b = 8'd1;  // held request must be ignored
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, y, in_ready} !== {1'b1, 8'd14, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: got ov=%b y=%0d rdy=%b, want 1,14,0", i, out_valid, y, in_ready);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready: got rdy=%b, want 1", in_ready);
        end
        step();
        n_cmp++;
        if ({out_valid, y} !== {1'b0, 8'd14}) begin
            n_err++;
            $display("FAIL bp_retire: got ov=%b y=%0d, want 0,14", out_valid, y);
        end
    endtask

    task automatic test_reset_mid_mul();
        in_valid = 1'b1; op = 3'd7; a = 8'd3; b = 8'd5;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, y, carry, zero, neg, ovf, busy} !== {1'b0, 8'd0, 5'b00000}) begin
            n_err++;
            $display("FAIL rst_mid_mul: got ov=%b y=%0d c=%b z=%b n=%b v=%b busy=%b, want all 0",
                     out_valid, y, carry, zero, neg, ovf, busy);
        end
        #2;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_release: got rdy=%b busy=%b, want 1,0", in_ready, busy);
        end
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_spurious cyc%0d: got ov=%b, want 0", i, out_valid);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_shift_logic();
        test_backpressure();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
